// File: rtl/component_decode_pkg.sv
// Shared constants and state encoding for the component decode sequencer.
package component_decode_pkg;

  localparam int unsigned MAX_BLOCKS = 8;
  localparam int unsigned COEFF_W    = 16;
  localparam int unsigned ADDR_W     = $clog2(MAX_BLOCKS * 64);
  localparam int unsigned POS_W      = 6;
  localparam int unsigned LAST_POS   = 63;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_DC      = 3'd2,
    ST_AC      = 3'd3,
    ST_AC_SKIP = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/component_coeff_stepper.sv
// AC slot walker: block is the inner index, scan position the outer index.
module component_coeff_stepper #(
  parameter int unsigned BI_W = 3,
  parameter int unsigned NB_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  input  logic            adv_i,
  input  logic [NB_W-1:0] nblk_i,
  output logic [BI_W-1:0] blk_o,
  output logic [5:0]      pos_o,
  output logic            last_o
);
  import component_decode_pkg::*;

  logic [BI_W-1:0] blk_q, blk_d;
  logic [5:0]      pos_q, pos_d;
  logic            blk_end;

  assign blk_end = (NB_W'(blk_q) + NB_W'(1)) == nblk_i;
  assign last_o  = blk_end && (pos_q == 6'(LAST_POS));
  assign blk_o   = blk_q;
  assign pos_o   = pos_q;

  // Holds at the last slot; the caller tracks running past the end.
  always_comb begin
    blk_d = blk_q;
    pos_d = pos_q;
    if (init_i) begin
      blk_d = '0;
      pos_d = 6'd1;
    end else if (adv_i && !last_o) begin
      if (blk_end) begin
        blk_d = '0;
        pos_d = pos_q + 6'd1;
      end else begin
        blk_d = blk_q + BI_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_q <= '0;
      pos_q <= '0;
    end else begin
      blk_q <= blk_d;
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/component_decode_sequencer.sv
// Sequences clear, DC and AC run/level writes of one component into coefficient memory.
module component_decode_sequencer #(
  parameter int unsigned MAX_BLOCKS = 8,
  parameter int unsigned COEFF_W    = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [31:0]                       block_num_i,
  input  logic                              dc_valid_i,
  output logic                              dc_ready_o,
  input  logic [COEFF_W-1:0]                dc_level_i,
  input  logic                              ac_valid_i,
  output logic                              ac_ready_o,
  input  logic [5:0]                        ac_run_i,
  input  logic [COEFF_W-1:0]                ac_level_i,
  input  logic                              ac_end_i,
  output logic                              coeff_wr_en_o,
  output logic [$clog2(MAX_BLOCKS*64)-1:0]  coeff_addr_o,
  output logic [COEFF_W-1:0]                coeff_wdata_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              error_o
);
  import component_decode_pkg::*;

  localparam int unsigned AW    = $clog2(MAX_BLOCKS * 64);
  localparam int unsigned BI_W  = AW - POS_W;
  localparam int unsigned NB_W  = BI_W + 1;
  localparam int unsigned CNT_W = AW + 1;

  state_e state_q, state_d;

  logic [NB_W-1:0]    nblk_q, nblk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COEFF_W-1:0] lvl_q, lvl_d;
  logic [5:0]         skip_q, skip_d;
  logic               past_q, past_d;
  logic               error_q, error_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [COEFF_W-1:0] wdata_q, wdata_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               dc_rdy_q, dc_rdy_d, ac_rdy_q, ac_rdy_d;

  logic            st_init, st_adv, st_last;
  logic [BI_W-1:0] st_blk;
  logic [5:0]      st_pos;
  logic            blk_ok, clr_last, dc_last, ac_data, ovf;

  assign blk_ok   = (block_num_i != 32'd0) && (block_num_i <= 32'(MAX_BLOCKS));
  assign clr_last = (cnt_q + CNT_W'(1)) == {nblk_q, 6'd0};
  assign dc_last  = (cnt_q + CNT_W'(1)) == CNT_W'(nblk_q);
  assign ac_data  = (state_q == ST_AC) && ac_valid_i && !ac_end_i;
  // Any skip or write attempted once the final slot has been consumed overruns.
  assign ovf      = past_q && (ac_data || (state_q == ST_AC_SKIP));

  component_coeff_stepper #(
    .BI_W (BI_W),
    .NB_W (NB_W)
  ) u_stepper (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .init_i (st_init),
    .adv_i  (st_adv),
    .nblk_i (nblk_q),
    .blk_o  (st_blk),
    .pos_o  (st_pos),
    .last_o (st_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = blk_ok ? ST_CLEAR : ST_FIN;
      ST_CLEAR:   if (clr_last) state_d = ST_DC;
      ST_DC:      if (dc_valid_i && dc_last) state_d = ST_AC;
      ST_AC: begin
        if (ac_valid_i) begin
          if (ac_end_i || ovf)    state_d = ST_FIN;
          else if (ac_run_i != 0) state_d = ST_AC_SKIP;
        end
      end
      ST_AC_SKIP: begin
        if (ovf)              state_d = ST_FIN;
        else if (skip_q == 0) state_d = ST_AC;
      end
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en_d = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    cnt_d   = cnt_q;
    nblk_d  = nblk_q;
    lvl_d   = lvl_q;
    skip_d  = skip_q;
    past_d  = past_q;
    error_d = error_q;
    st_init = 1'b0;
    st_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (blk_ok) begin
            nblk_d  = NB_W'(block_num_i);
            cnt_d   = '0;
            past_d  = 1'b0;
            error_d = 1'b0;
            st_init = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d = 1'b1;
        addr_d  = AW'(cnt_q);
        cnt_d   = clr_last ? '0 : cnt_q + CNT_W'(1);
      end
      ST_DC: begin
        if (dc_valid_i) begin
          wr_en_d = 1'b1;
          addr_d  = AW'({cnt_q, 6'd0});
          wdata_d = dc_level_i;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_AC: begin
        if (ac_data) begin
          if (past_q) begin
            error_d = 1'b1;
          end else if (ac_run_i == 0) begin
            wr_en_d = 1'b1;
            addr_d  = {st_blk, st_pos};
            wdata_d = ac_level_i;
            st_adv  = 1'b1;
          end else begin
            lvl_d   = ac_level_i;
            skip_d  = ac_run_i - 6'd1;
            st_adv  = 1'b1;
          end
        end
      end
      ST_AC_SKIP: begin
        if (past_q) begin
          error_d = 1'b1;
        end else if (skip_q != 0) begin
          skip_d = skip_q - 6'd1;
          st_adv = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = {st_blk, st_pos};
          wdata_d = lvl_q;
          st_adv  = 1'b1;
        end
      end
      default: ;
    endcase
    if (st_adv && st_last) past_d = 1'b1;
    busy_d   = state_d != ST_IDLE;
    done_d   = state_d == ST_FIN;
    dc_rdy_d = state_d == ST_DC;
    ac_rdy_d = state_d == ST_AC;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nblk_q   <= '0;
      cnt_q    <= '0;
      lvl_q    <= '0;
      skip_q   <= '0;
      past_q   <= 1'b0;
      error_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dc_rdy_q <= 1'b0;
      ac_rdy_q <= 1'b0;
    end else begin
      nblk_q   <= nblk_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      skip_q   <= skip_d;
      past_q   <= past_d;
      error_q  <= error_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dc_rdy_q <= dc_rdy_d;
      ac_rdy_q <= ac_rdy_d;
    end
  end

  assign coeff_wr_en_o = wr_en_q;
  assign coeff_addr_o  = addr_q;
  assign coeff_wdata_o = wdata_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign dc_ready_o    = dc_rdy_q;
  assign ac_ready_o    = ac_rdy_q;

endmodule

// File: tb/tb_component_decode_sequencer.sv
// Directed bench for component_decode_sequencer with a slot-arithmetic write model.
module tb_component_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [31:0] block_num = '0;
  logic        dc_valid = 1'b0;
  logic        dc_ready;
  logic [15:0] dc_level = '0;
  logic        ac_valid = 1'b0;
  logic        ac_ready;
  logic [5:0]  ac_run = '0;
  logic [15:0] ac_level = '0;
  logic        ac_end = 1'b0;
  logic        wr_en;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic        busy, done, error;

  component_decode_sequencer #(.MAX_BLOCKS(8), .COEFF_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .block_num_i   (block_num),
    .dc_valid_i    (dc_valid),
    .dc_ready_o    (dc_ready),
    .dc_level_i    (dc_level),
    .ac_valid_i    (ac_valid),
    .ac_ready_o    (ac_ready),
    .ac_run_i      (ac_run),
    .ac_level_i    (ac_level),
    .ac_end_i      (ac_end),
    .coeff_wr_en_o (wr_en),
    .coeff_addr_o  (addr),
    .coeff_wdata_o (wdata),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          n_wr = 0;
  logic [15:0] mem [0:511];
  int          dcv [8];
  int          acr [8];
  int          acl [8];
  int          ace [8];
  int          low_cnt [8];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected write stream from slot index arithmetic: slot s -> block s%n, pos s/n+1.
  task automatic build_model(input logic [31:0] n, input int nac, output bit err);
    int nb, total, s, tgt;
    wr_t w;
    err = 1'b0;
    if (n == 32'd0 || n > 32'd8) begin
      err = 1'b1;
      return;
    end
    nb = int'(n);
    for (int a = 0; a < nb * 64; a++) begin
      w.addr = a; w.data = 16'd0; exp_q.push_back(w);
    end
    for (int k = 0; k < nb; k++) begin
      w.addr = k * 64; w.data = 16'(dcv[k]); exp_q.push_back(w);
    end
    total = 63 * nb;
    s = 0;
    for (int i = 0; i < nac; i++) begin
      if (ace[i] != 0) break;
      tgt = s + acr[i];
      if (tgt >= total) begin
        err = 1'b1;
        break;
      end
      w.addr = (tgt % nb) * 64 + tgt / nb + 1;
      w.data = 16'(acl[i]);
      exp_q.push_back(w);
      s = tgt + 1;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0) begin
      if (done) done_cnt++;
      if (wr_en) begin
        n_wr++;
        mem[addr] = wdata;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", int'(addr), -1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(addr), e.addr);
          chk("wr_data", int'(wdata), int'(e.data));
        end
      end
    end
  end

  task automatic send_dc(input int v);
    int t = 0;
    while (!dc_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) chk("dc_ready_wait", 0, 1);
    dc_valid = 1'b1; dc_level = 16'(v);
    @(posedge clk); #1;
    dc_valid = 1'b0;
  endtask

  task automatic send_ac(input int i);
    int t = 0;
    int lc = 0;
    while (!ac_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) chk("ac_ready_wait", 0, 1);
    ac_valid = 1'b1; ac_run = 6'(acr[i]); ac_level = 16'(acl[i]); ac_end = (ace[i] != 0);
    @(posedge clk); #1;
    ac_valid = 1'b0; ac_end = 1'b0;
    while (!ac_ready && busy && lc < 200) begin
      @(posedge clk); #1; lc++;
    end
    low_cnt[i] = lc;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    @(posedge clk); #1;
    start = 1'b1; block_num = n;
    @(posedge clk); #1;
    start = 1'b0; block_num = '0;
  endtask

  task automatic run_component(input logic [31:0] n, input int nac, input bit poke);
    bit exp_err;
    bit valid;
    int exp_n, wbase, dbase, t;
    build_model(n, nac, exp_err);
    exp_n = exp_q.size();
    wbase = n_wr;
    dbase = done_cnt;
    valid = (n >= 32'd1 && n <= 32'd8);
    pulse_start(n);
    if (!valid) begin
      chk("bad_done_next", int'(done), 1);
      chk("bad_error", int'(error), 1);
    end
    if (poke) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; block_num = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; block_num = '0;
    end
    if (valid) begin
      for (int k = 0; k < int'(n); k++) send_dc(dcv[k]);
      for (int i = 0; i < nac; i++) send_ac(i);
    end
    t = 0;
    while (done_cnt == dbase && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 3000) chk("done_wait", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("error_flag", int'(error), int'(exp_err));
    chk("write_count", n_wr - wbase, exp_n);
    chk("writes_left", exp_q.size(), 0);
    chk("done_once", done_cnt - dbase, 1);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic load_t1();
    dcv[0] = 5;
    acr[0] = 0; acl[0] = 3;  ace[0] = 0;
    acr[1] = 0; acl[1] = -2; ace[1] = 0;
    acr[2] = 0; acl[2] = 0;  ace[2] = 1;
  endtask

  initial begin
    bit e;
    int t;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'({busy, done, error, dc_ready, ac_ready, wr_en, addr, wdata}), 0);
    rst = 1'b0;

    // Single block, two run-0 levels
    load_t1();
    run_component(32'd1, 3, 1'b0);
    chk("t1_mem0", int'(mem[0]), 5);
    chk("t1_mem1", int'(mem[1]), 3);
    chk("t1_mem2", int'(mem[2]), 32'hFFFE);
    chk("t1_mem3", int'(mem[3]), 0);

    // Two blocks, interleaved slot order and a run of 2
    dcv[0] = 7; dcv[1] = 9;
    acr[0] = 0; acl[0] = 1; ace[0] = 0;
    acr[1] = 2; acl[1] = 4; ace[1] = 0;
    acr[2] = 0; acl[2] = 0; ace[2] = 1;
    run_component(32'd2, 3, 1'b0);
    chk("t2_mem0", int'(mem[0]), 7);
    chk("t2_mem64", int'(mem[64]), 9);
    chk("t2_mem1", int'(mem[1]), 1);
    chk("t2_mem66", int'(mem[66]), 4);
    chk("t2_mem65", int'(mem[65]), 0);
    chk("t2_mem2", int'(mem[2]), 0);
    chk("t2_run0_ready_low", low_cnt[0], 0);
    chk("t2_skip_ready_low", low_cnt[1], 2);

    // Run overshoots the 63 slots of one block
    dcv[0] = 5;
    acr[0] = 63; acl[0] = 7; ace[0] = 0;
    run_component(32'd1, 1, 1'b0);
    chk("t3_error", int'(error), 1);

    // Write landing exactly on the last slot is legal
    dcv[0] = 0;
    acr[0] = 62; acl[0] = 8; ace[0] = 0;
    acr[1] = 0;  acl[1] = 0; ace[1] = 1;
    run_component(32'd1, 2, 1'b0);
    chk("t4_mem63", int'(mem[63]), 8);
    chk("t4_mem62", int'(mem[62]), 0);
    chk("t4_error", int'(error), 0);

    // Out-of-range block counts
    run_component(32'd0, 0, 1'b0);
    run_component(32'd9, 0, 1'b0);
    run_component(32'h0000_0101, 0, 1'b0);

    // Start pulsed mid-decode is ignored
    load_t1();
    run_component(32'd1, 3, 1'b1);

    // Reset while skipping inside a three-block decode
    dcv[0] = 1; dcv[1] = 2; dcv[2] = 3;
    acr[0] = 40; acl[0] = 11; ace[0] = 0;
    build_model(32'd3, 1, e);
    pulse_start(32'd3);
    for (int k = 0; k < 3; k++) send_dc(dcv[k]);
    t = 0;
    while (!ac_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) chk("rst_ac_wait", 0, 1);
    ac_valid = 1'b1; ac_run = 6'd40; ac_level = 16'd11;
    @(posedge clk); #1;
    ac_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_ac_ready", int'(ac_ready), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", int'({busy, done, error, dc_ready, ac_ready, wr_en, addr, wdata}), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    load_t1();
    run_component(32'd1, 3, 1'b0);
    chk("post_rst_mem1", int'(mem[1]), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/component_decode_sequencer.md
COMPONENT_DECODE_SEQUENCER -- requirements
Module: component_decode_sequencer

Interface
REQ-001 Parameter MAX_BLOCKS, default 8: maximum number of 8x8 blocks per component.
REQ-002 Parameter COEFF_W, default 16: signed coefficient width.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins one component decode.
REQ-006 block_num  input  32  blocks in this component, sampled on accepted start.
REQ-007 dc_valid / dc_ready  input / output  1 / 1  DC level handshake from the DC VLD.
REQ-008 dc_level  input  COEFF_W  decoded DC value.
REQ-009 ac_valid / ac_ready  input / output  1 / 1  AC run/level handshake from the AC VLD.
REQ-010 ac_run  input  6  zero run preceding ac_level.
REQ-011 ac_level  input  COEFF_W  decoded AC value.
REQ-012 ac_end  input  1  qualifies ac_valid: end of component, run/level ignored.
REQ-013 coeff_wr_en  output  1  coefficient memory write strobe.
REQ-014 coeff_addr  output  clog2(MAX_BLOCKS*64)  address = block*64 + scan position.
REQ-015 coeff_wdata  output  COEFF_W  write data.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at end of component.
REQ-018 error  output  1  sticky until next accepted start.

Function
REQ-019 FSM states are IDLE, CLEAR, DC, AC, AC_SKIP, and FIN.
REQ-020 IDLE: start is accepted only if 1 <= block_num <= MAX_BLOCKS; otherwise error=1 and done pulses the next cycle, with no writes.
REQ-021 start is ignored while busy.
REQ-022 CLEAR: write 0 to addresses 0 .. block_num*64-1, one per cycle, ascending, then go to DC.
REQ-023 DC: dc_ready=1; the k-th accepted DC writes dc_level to address k*64; after block_num DCs, go to AC with block=0, pos=1.
REQ-024 AC ordering: block is the inner loop (0..block_num-1) and pos is the outer loop (1..63); total slots = 63*block_num.
REQ-025 AC: ac_ready=1 only in AC state.
REQ-026 Accepted ac_run=0: write ac_level at the current slot, then advance one slot.
REQ-027 Accepted ac_run=r>0: register the level, go to AC_SKIP, advance r slots with no writes (one per cycle), then write the level and advance; return to AC.
REQ-028 Accepted ac_end=1 goes to FIN regardless of position; unwritten slots remain 0 from CLEAR.
REQ-029 Advancing past the last slot, whether by skip or write, sets error, suppresses the write, and goes to FIN.
REQ-030 A write exactly to the last slot is legal; the sequencer then waits in AC for ac_end.
REQ-031 FIN: done=1 for one cycle, then IDLE.
REQ-032 coeff_wr_en, coeff_addr, and coeff_wdata are registered and appear one cycle after the causing event; at most one write per cycle.
REQ-033 Address arithmetic is unsigned with no wrap; block_num upper bits above clog2(MAX_BLOCKS)+1 must be zero, otherwise error per REQ-020.

Reset
REQ-034 Reset forces IDLE at any time, including mid-component.
REQ-035 Under reset all outputs are 0: busy, done, error, dc_ready, ac_ready, coeff_wr_en, coeff_addr, and coeff_wdata.
REQ-036 All counters and registered levels clear to 0 on reset.

Structure
REQ-037 Package component_decode_pkg holds MAX_BLOCKS, COEFF_W, the state enumeration, and the address-width constant.
REQ-038 Sub-module component_coeff_stepper holds the block/pos counters, provides the advance input and last-slot flag, and is instantiated once.

Verification
REQ-039 block_num=1, 1 DC (5), AC run0 levels 3,-2, then ac_end -> 64 zero writes; addr0=5, addr1=3, addr2=-2; done pulses once.
REQ-040 block_num=2, DCs 7,9, AC (run0,1),(run2,4), end -> addr0=7, addr64=9, addr1=1, then skip (65,2) to write addr66=4; ac_ready low for 2 cycles.
REQ-041 block_num=1, run63 -> overshoots slot count 63: error=1, no write, done pulses.
REQ-042 block_num=0 and block_num=9 -> error=1 and done next cycle, with no coeff_wr_en.
REQ-043 Assert reset during AC_SKIP of a 3-block decode -> all outputs 0 immediately; a new start with block_num=1 completes cleanly.
REQ-044 start pulsed while busy -> ignored; write count equals the first component's only.
